// File: rtl/snn_step_scheduler.sv
// Time-step sequencer for a small spiking neuron array. It clears the array,
// issues TS step strobes spaced STEP_CYCLES apart, and reports each neuron's
// first spike once per run as an AXI-stream beat {neuron id, step stamp},
// choosing among pending neurons round-robin.
module snn_step_scheduler #(
  parameter int N           = 4,
  parameter int TS          = 16,
  parameter int STEP_CYCLES = 4,
  localparam int IDW        = $clog2(N),
  localparam int TW         = $clog2(TS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               neuron_clear,
  output logic               time_step,
  input  logic [N-1:0]       spike_valid,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [IDW+TW-1:0]  m_tdata
);

  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0]  CYC_LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0]  STEP_LAST = TW'(TS - 1);
  localparam logic [IDW-1:0] ID_LAST   = IDW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic [TW-1:0]       step_q, step_d;
  logic [N-1:0]        pending_q, pending_d;
  logic [N-1:0]        reported_q, reported_d;
  logic [IDW-1:0]      last_q, last_d;
  logic                tvalid_q, tvalid_d;
  logic [IDW+TW-1:0]   tdata_q, tdata_d;
  logic                drain_seen_q, drain_seen_d;
  logic [TW-1:0]       stamp_q [N];

  logic                active;
  logic [N-1:0]        det;
  logic                gnt_found;
  logic [IDW-1:0]      gnt_id;
  logic [IDW-1:0]      rr_idx;
  logic                load_en;
  logic [N-1:0]        gnt_oh;

  assign m_tvalid = tvalid_q;
  assign m_tdata  = tdata_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded control outputs
  always_comb begin
    state_d      = state_q;
    busy         = 1'b1;
    done         = 1'b0;
    neuron_clear = 1'b0;
    time_step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        neuron_clear = 1'b1;
        state_d      = S_RUN;
      end
      S_RUN: begin
        if (cyc_q == CYC_LAST) begin
          time_step = 1'b1;
          if (step_q == STEP_LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // First DRAIN cycle always passes so late spikes get a chance to land
        if (drain_seen_q && (pending_q == '0) && !tvalid_q) state_d = S_FIN;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Round-robin pick: first pending index strictly after the last grant
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    rr_idx    = '0;
    for (int k = 1; k <= N; k++) begin
      rr_idx = IDW'((int'(last_q) + k) % N);
      if (!gnt_found && pending_q[rr_idx]) begin
        gnt_found = 1'b1;
        gnt_id    = rr_idx;
      end
    end
  end

  // Detection, grant and counter next-state values
  always_comb begin
    active   = (state_q == S_RUN) || (state_q == S_DRAIN);
    det      = active ? (spike_valid & ~reported_q & ~pending_q) : '0;
    // The output register may reload in the same cycle its beat is accepted
    load_en  = active && gnt_found && (!tvalid_q || m_tready);
    gnt_oh   = load_en ? ({{(N-1){1'b0}}, 1'b1} << gnt_id) : '0;

    cyc_d        = cyc_q;
    step_d       = step_q;
    pending_d    = (pending_q | det) & ~gnt_oh;
    reported_d   = reported_q | gnt_oh;
    last_d       = load_en ? gnt_id : last_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    drain_seen_d = (state_q == S_DRAIN);

    if (load_en) begin
      tvalid_d = 1'b1;
      tdata_d  = {gnt_id, stamp_q[gnt_id]};
    end else if (tvalid_q && m_tready) begin
      tvalid_d = 1'b0;
    end

    if (state_q == S_CLEAR) begin
      cyc_d      = '0;
      step_d     = '0;
      pending_d  = '0;
      reported_d = '0;
      last_d     = ID_LAST;
    end else if (state_q == S_RUN) begin
      if (cyc_q == CYC_LAST) begin
        cyc_d  = '0;
        step_d = step_q + 1'b1;
      end else begin
        cyc_d  = cyc_q + 1'b1;
      end
    end
  end

  // Counters, masks, output beat register and per-neuron stamps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q        <= '0;
      step_q       <= '0;
      pending_q    <= '0;
      reported_q   <= '0;
      last_q       <= ID_LAST;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      drain_seen_q <= 1'b0;
      for (int i = 0; i < N; i++) stamp_q[i] <= '0;
    end else begin
      cyc_q        <= cyc_d;
      step_q       <= step_d;
      pending_q    <= pending_d;
      reported_q   <= reported_d;
      last_q       <= last_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      drain_seen_q <= drain_seen_d;
      for (int i = 0; i < N; i++) begin
        if (det[i]) stamp_q[i] <= step_q;
      end
    end
  end

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Directed bench for snn_step_scheduler with N=4, TS=4, STEP_CYCLES=4.
// Expected spike reports are queued as stimulus is applied and compared as
// the DUT completes each AXI-stream beat.
module tb_snn_step_scheduler;
  localparam int N   = 4;
  localparam int TS  = 4;
  localparam int SC  = 4;
  localparam int IDW = 2;
  localparam int TW  = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             m_tready = 1'b1;
  logic [N-1:0]     spike_valid = '0;
  logic             busy, done, neuron_clear, time_step, m_tvalid;
  logic [IDW+TW-1:0] m_tdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int clr_cnt = 0, ts_cnt = 0, done_cnt = 0, beat_cnt = 0, stall_cnt = 0;
  int ts_run = 0, clr_cyc = 0, last_ts_cyc = 0, last_beat_cyc = 0, prev_beat_cyc = 0;
  logic             prev_stall = 1'b0;
  logic [IDW+TW-1:0] prev_data = '0;
  logic [IDW+TW-1:0] exp_q [$];

  always #5 clk = ~clk;

  snn_step_scheduler #(.N(N), .TS(TS), .STEP_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .neuron_clear(neuron_clear), .time_step(time_step),
    .spike_valid(spike_valid), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata)
  );

  function automatic logic [IDW+TW-1:0] enc(input int id, input int st);
    logic [31:0] i32, s32;
    i32 = id;
    s32 = st;
    return {i32[IDW-1:0], s32[TW-1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_pulses(input int target);
    int n = 0;
    while (ts_cnt < target && n < 100) begin
      step(1);
      n++;
    end
    check("pulse_wait", ts_cnt >= target, 1);
  endtask

  task automatic wait_tvalid();
    int n = 0;
    while (!m_tvalid && n < 50) begin
      step(1);
      n++;
    end
    check("tvalid_wait", m_tvalid, 1);
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_cnt == base && n < 200) begin
      step(1);
      n++;
    end
    check("done_wait", done_cnt != base, 1);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (neuron_clear) begin
        clr_cnt++;
        clr_cyc = cyc;
        ts_run  = 0;
      end
      if (time_step) begin
        if (ts_run == 0) check("first_step_latency", cyc - clr_cyc, SC);
        else             check("step_spacing", cyc - last_ts_cyc, SC);
        ts_run++;
        ts_cnt++;
        last_ts_cyc = cyc;
      end
      if (prev_stall) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, prev_data);
      end
      if (m_tvalid && !m_tready) stall_cnt++;
      if (m_tvalid && m_tready) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("beat_data", m_tdata, exp_q.pop_front());
        beat_cnt++;
        prev_beat_cyc = last_beat_cyc;
        last_beat_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_queue_empty", exp_q.size(), 0);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr_b, ts_b, done_b, beat_b, stall_b;

    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clear", neuron_clear, 0);
    check("rst_step", time_step, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    step(2);
    reset = 1'b1;
    step(2);
    check("idle_busy", busy, 0);

    // Normal run, no spikes
    clr_b = clr_cnt; ts_b = ts_cnt; done_b = done_cnt; beat_b = beat_cnt;
    run_start();
    check("clear_pulse", neuron_clear, 1);
    check("busy_in_clear", busy, 1);
    wait_done(done_b);
    step(2);
    check("r1_clears", clr_cnt - clr_b, 1);
    check("r1_steps", ts_cnt - ts_b, TS);
    check("r1_dones", done_cnt - done_b, 1);
    check("r1_beats", beat_cnt - beat_b, 0);
    check("r1_idle", busy, 0);

    // Simultaneous spikes on neurons 1 and 3 after pulse 2
    ts_b = ts_cnt; done_b = done_cnt; beat_b = beat_cnt;
    run_start();
    wait_pulses(ts_b + 2);
    spike_valid = 4'b1010;
    exp_q.push_back(enc(1, 2));
    exp_q.push_back(enc(3, 2));
    wait_done(done_b);
    check("r2_beats", beat_cnt - beat_b, 2);
    check("r2_back_to_back", last_beat_cyc - prev_beat_cyc, 1);
    spike_valid = '0;
    step(2);

    // Backpressure: ready low for 10 cycles of a held beat
    ts_b = ts_cnt; done_b = done_cnt; beat_b = beat_cnt; stall_b = stall_cnt;
    run_start();
    wait_pulses(ts_b + 1);
    m_tready = 1'b0;
    spike_valid = 4'b0101;
    exp_q.push_back(enc(0, 1));
    exp_q.push_back(enc(2, 1));
    wait_tvalid();
    step(10);
    m_tready = 1'b1;
    wait_done(done_b);
    check("r3_stall_cycles", stall_cnt - stall_b, 10);
    check("r3_beats", beat_cnt - beat_b, 2);
    check("r3_steps", ts_cnt - ts_b, TS);
    spike_valid = '0;
    step(2);

    // Round-robin: after granting 2, neurons 0 and 3 pending -> 3 first
    ts_b = ts_cnt; done_b = done_cnt; beat_b = beat_cnt;
    run_start();
    wait_pulses(ts_b + 1);
    spike_valid = 4'b0100;
    exp_q.push_back(enc(2, 1));
    wait_tvalid();
    spike_valid = 4'b1101;
    exp_q.push_back(enc(3, 1));
    exp_q.push_back(enc(0, 1));
    wait_done(done_b);
    check("r4_beats", beat_cnt - beat_b, 3);
    spike_valid = '0;
    step(2);

    // Late fire after the last pulse, reported during DRAIN
    ts_b = ts_cnt; done_b = done_cnt; beat_b = beat_cnt;
    run_start();
    wait_pulses(ts_b + TS);
    spike_valid = 4'b0010;
    exp_q.push_back(enc(1, 4));
    wait_done(done_b);
    check("r5_beats", beat_cnt - beat_b, 1);
    check("r5_beat_after_last_step", last_beat_cyc > last_ts_cyc, 1);
    spike_valid = '0;
    step(2);

    // Abort mid-run with a held beat
    ts_b = ts_cnt; done_b = done_cnt;
    run_start();
    wait_pulses(ts_b + 1);
    m_tready = 1'b0;
    spike_valid = 4'b0001;
    exp_q.push_back(enc(0, 1));
    wait_tvalid();
    step(2);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_clear", neuron_clear, 0);
    check("abort_step", time_step, 0);
    check("abort_tvalid", m_tvalid, 0);
    check("abort_tdata", m_tdata, 0);
    exp_q.delete();
    m_tready = 1'b1;
    spike_valid = '0;
    step(3);
    check("abort_no_done", done_cnt - done_b, 0);
    reset = 1'b1;
    step(1);

    // Clean run after abort; start while busy is ignored
    clr_b = clr_cnt; ts_b = ts_cnt; done_b = done_cnt; beat_b = beat_cnt;
    run_start();
    step(3);
    start = 1'b1;
    step(3);
    start = 1'b0;
    wait_pulses(ts_b + 1);
    spike_valid = 4'b0001;
    exp_q.push_back(enc(0, 1));
    wait_done(done_b);
    check("r7_clears", clr_cnt - clr_b, 1);
    check("r7_steps", ts_cnt - ts_b, TS);
    check("r7_dones", done_cnt - done_b, 1);
    check("r7_beats", beat_cnt - beat_b, 1);
    spike_valid = '0;
    step(3);
    check("r7_idle", busy, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snn_step_scheduler.md
SNN_STEP_SCHEDULER -- requirements
Module: snn_step_scheduler

Interface
REQ-001 Parameter N, default 4: number of neurons sequenced; legal range 2..64.
REQ-002 Parameter TS, default 16: time steps per inference run; minimum 1.
REQ-003 Parameter STEP_CYCLES, default 4: clock cycles per time step; minimum 2.
REQ-004 Derived widths: IDW = clog2(N) and TW = clog2(TS+1).
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port start, input, 1: level-sampled request to begin a run.
REQ-008 Port busy, output, 1: high in every state except IDLE.
REQ-009 Port done, output, 1: one-cycle pulse marking the end of a run.
REQ-010 Port neuron_clear, output, 1: one-cycle pulse that clears the neuron array before a run.
REQ-011 Port time_step, output, 1: one-cycle step strobe to all neurons.
REQ-012 Port spike_valid, input, N: per-neuron sticky "fired" flag (neuron tvalid).
REQ-013 Port m_tvalid, output, 1: AXI-stream valid for spike reports.
REQ-014 Port m_tready, input, 1: AXI-stream ready for spike reports.
REQ-015 Port m_tdata, output, IDW+TW: spike report as {neuron id, step stamp}.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, RUN, DRAIN and FIN.
REQ-017 IDLE SHALL move to CLEAR on the first cycle start=1; start SHALL be ignored in all other states.
REQ-018 CLEAR SHALL last exactly 1 cycle with neuron_clear=1, clear the step count, cycle count, reported mask and pending mask, then move to RUN.
REQ-019 RUN cycle counter: counts 0..STEP_CYCLES-1 and wraps to 0.
REQ-020 RUN time_step: asserted for 1 cycle when the cycle counter = STEP_CYCLES-1; the step count (TW bits, 0..TS) increments in the same cycle.
REQ-021 The first time_step SHALL occur STEP_CYCLES cycles after RUN entry.
REQ-022 RUN SHALL move to DRAIN in the cycle after the TS-th time_step.
REQ-023 Exactly TS time_step pulses SHALL be issued per run.
REQ-024 Detection: in RUN or DRAIN, any i with spike_valid[i]=1, reported[i]=0 and pending[i]=0 sets pending[i] and captures stamp[i] = current step count (1-based index of the latest pulse, 0 if none yet).
REQ-025 spike_valid SHALL be ignored in IDLE, CLEAR and FIN.
REQ-026 Each neuron SHALL be reported at most once per run, even though spike_valid stays high.
REQ-027 Arbitration: when no beat is held and pending≠0, select the lowest pending index strictly after the last granted index, wrapping modulo N (round-robin); after reset or CLEAR the last granted index = N-1, so index 0 has first priority.
REQ-028 The selected neuron SHALL be loaded into the output register with m_tvalid=1 and m_tdata={id, stamp[id]}; its pending bit clears and its reported bit sets in the same cycle.
REQ-029 m_tvalid and m_tdata SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-030 A beat completes on m_tvalid & m_tready.
REQ-031 A new beat MAY load in the same cycle a beat completes; the output register sustains 1 beat per cycle.
REQ-032 Detection and grant in the same cycle for different neurons SHALL both take effect.
REQ-033 A neuron detected in cycle t SHALL be eligible for grant no earlier than cycle t+1.
REQ-034 DRAIN SHALL last at least 2 cycles.
REQ-035 DRAIN SHALL move to FIN in the first cycle, from the 2nd DRAIN cycle on, in which pending=0 and m_tvalid=0.
REQ-036 FIN SHALL last 1 cycle with done=1, then move to IDLE.
REQ-037 Neurons that never fired SHALL produce no report.
REQ-038 The step count SHALL never exceed TS.
REQ-039 time_step SHALL be 0 outside RUN.

Reset
REQ-040 On reset=0, asynchronously: state=IDLE; busy, done, neuron_clear, time_step and m_tvalid = 0; m_tdata = 0; all counters and masks = 0; last granted index = N-1.
REQ-041 Reset mid-run SHALL abort immediately, drop any held beat without completing it, and produce no done pulse.
REQ-042 Reset release SHALL take effect on the first clk edge after reset rises.

Verification (N=4, TS=4, STEP_CYCLES=4, m_tready=1 unless stated)
REQ-043 Scenario, normal run: start pulse with no spikes -> neuron_clear 1 cycle; 4 time_step pulses spaced 4 cycles apart; done exactly once; no m_tvalid.
REQ-044 Scenario, simultaneous spikes: spike_valid=4'b1010 after pulse 2 -> beats {1,2} then {3,2} on consecutive cycles; no repeats while spike_valid stays high.
REQ-045 Scenario, backpressure: m_tready=0 for 10 cycles while neurons 0 and 2 fire after pulse 1 -> {0,1} held stable for 10 cycles, then {2,1}; done only after both beats complete.
REQ-046 Scenario, round-robin: after the grant to neuron 2, neurons 0 and 3 become pending -> neuron 3 is granted before neuron 0.
REQ-047 Scenario, late fire: neuron 1 fires after pulse 4 -> beat {1,4} during DRAIN, then done.
REQ-048 Scenario, abort and ignore: reset=0 during RUN with a held beat -> all outputs 0 asynchronously; a later start gives a clean run with stamps restarting at 1; start asserted while busy -> ignored.
